// File: rtl/fb_sram_arbiter.sv
// fb_sram_arbiter: shares one asynchronous SRAM between display reads and
// draw-engine writes. Each access takes two cycles, and the arbiter
// re-arbitrates on the last cycle of every access. Reads win ties until a
// waiting write has been passed over STARVE_MAX times.
module fb_sram_arbiter #(
    parameter int AW         = 20,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_we_n,
    output logic          mem_oe_n,
    output logic          busy
);

    localparam int            SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        WR1,
        WR2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_grant_rd;
    logic          w_grant_wr;
    logic [SW-1:0] r_starve;
    logic          r_rd_ack;
    logic          r_wr_ack;
    logic          r_rd_valid;
    logic [DW-1:0] r_rd_data;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_mem_we_n;
    logic          r_mem_oe_n;

    // State register.
    always_ff @(posedge Clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of block evaluation order.
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and grants; IDLE, RD2 and WR2 are the arbitration points.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        w_next     = IDLE;
        w_grant_rd = 1'b0;
        w_grant_wr = 1'b0;
        unique case (r_state)
            RD1: w_next = RD2;
            WR1: w_next = WR2;
            default: begin
                if (rd_req && (!wr_req || (r_starve != STARVE_LIM))) begin
                    w_grant_rd = 1'b1;
                    w_next     = RD1;
                end else if (wr_req) begin
                    w_grant_wr = 1'b1;
                    w_next     = WR1;
                end
            end
        endcase
    end

    // Count reads granted while a write waits; saturates at STARVE_MAX.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_starve <= '0;
        end else if (!wr_req || w_grant_wr) begin
            r_starve <= '0;
        end else if (w_grant_rd && (r_starve != STARVE_LIM)) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    // Registered SRAM strobes, address/data latch and grant pulses.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_rd_ack    <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we_n  <= 1'b1;
            r_mem_oe_n  <= 1'b1;
        end else begin
            r_rd_ack   <= w_grant_rd;
            r_wr_ack   <= w_grant_wr;
            // Strobes follow the state being entered, so they can never overlap.
            r_mem_oe_n <= !((w_next == RD1) || (w_next == RD2));
            r_mem_we_n <= (w_next != WR1);
            if (w_grant_rd) begin
                r_mem_addr <= rd_addr;
            end else if (w_grant_wr) begin
                r_mem_addr  <= wr_addr;
                r_mem_wdata <= wr_data;
            end
        end
    end

    // Capture read data on the edge that leaves RD2; hold it until the next read.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= (r_state == RD2);
            if (r_state == RD2) begin
                r_rd_data <= mem_rdata;
            end
        end
    end

    assign rd_ack    = r_rd_ack;
    assign wr_ack    = r_wr_ack;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we_n  = r_mem_we_n;
    assign mem_oe_n  = r_mem_oe_n;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// tb_fb_sram_arbiter: scoreboard bench for fb_sram_arbiter. The requester
// tasks push expected transactions, and a negedge monitor pops and compares
// them whenever the DUT acks, strobes or returns data. The SRAM is a fixed
// address-to-word function, so the expected read data is known when a read
// is issued.
module tb_fb_sram_arbiter;

    localparam int AW         = 20;
    localparam int DW         = 16;
    localparam int STARVE_MAX = 4;
    localparam int BUDGET     = 40;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_we_n;
    logic          mem_oe_n;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    txn_t rd_q[$];
    txn_t wr_q[$];
    bit   grant_q[$];   // expected grant order: 0 = read, 1 = write
    bit   chk_order = 1'b0;
    int   last_ack  = -1;

    logic rst_at_edge = 1'b1;
    logic wr_at_edge  = 1'b0;

    fb_sram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ack   (rd_ack),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_we_n (mem_we_n),
        .mem_oe_n (mem_oe_n),
        .busy     (busy)
    );

    always #5 Clk = ~Clk;

    // SRAM contents: one fixed word at 0x00100, a scrambled address elsewhere.
    function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
        if (a == 20'h00100) return 16'hBEEF;
        return a[15:0] ^ {a[19:16], a[19:16], 8'h96};
    endfunction

    assign mem_rdata = mem_oe_n ? '0 : sram_word(mem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Issue one read, hold it until rd_ack is seen, and report the cycles waited.
    task automatic rd_issue(input logic [AW-1:0] a, output int lat);
        txn_t t;
        t.addr = a;
        t.data = sram_word(a);
        rd_q.push_back(t);
        rd_req  = 1'b1;
        rd_addr = a;
        lat     = 0;
        do begin
            @(posedge Clk);
            #1;
            lat++;
        end while (!rd_ack && lat < BUDGET);
        check("rd_ack_seen", rd_ack, 1'b1);
    endtask

    task automatic wr_issue(input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
        txn_t t;
        t.addr = a;
        t.data = d;
        wr_q.push_back(t);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        lat     = 0;
        do begin
            @(posedge Clk);
            #1;
            lat++;
        end while (!wr_ack && lat < BUDGET);
        check("wr_ack_seen", wr_ack, 1'b1);
    endtask

    // A gap of 0 re-issues in the ack cycle, which makes the reads back-to-back.
    task automatic reader(input int n, input int max_gap);
        int lat;
        int gap;
        for (int i = 0; i < n; i++) begin
            rd_issue(AW'($urandom()), lat);
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            if (gap > 0 || i == n - 1) begin
                rd_req = 1'b0;
                idle(gap);
            end
        end
    endtask

    task automatic writer(input int n, input int max_gap);
        int lat;
        int gap;
        for (int i = 0; i < n; i++) begin
            wr_issue(AW'($urandom()), DW'($urandom()), lat);
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            if (gap > 0 || i == n - 1) begin
                wr_req = 1'b0;
                idle(gap);
            end
        end
    endtask

    // Sample the inputs as the DUT sees them at the active edge.
    always @(posedge Clk) begin
        cyc++;
        rst_at_edge = !Reset;
        wr_at_edge  = wr_req;
    end

    // Monitor: pops and compares the scoreboard queues and checks the
    // cycle-level contract against ack history.
    always @(negedge Clk) begin : monitor
        static logic          prev_ack     = 1'b0;
        static logic          prev_rd_ack  = 1'b0;
        static logic          prev2_rd_ack = 1'b0;
        static logic          prev_we_low  = 1'b0;
        static logic [DW-1:0] last_rd_data = '0;
        static logic [AW+DW-1:0] hold_wr   = '0;
        static int            starve_obs   = 0;
        txn_t e;
        if (rst_at_edge) begin
            check("reset_outputs",
                  {rd_ack, wr_ack, rd_valid, busy, mem_we_n, mem_oe_n, rd_data, mem_addr, mem_wdata},
                  {4'b0000, 2'b11, 16'h0, 20'h0, 16'h0});
            prev_ack     = 1'b0;
            prev_rd_ack  = 1'b0;
            prev2_rd_ack = 1'b0;
            prev_we_low  = 1'b0;
            last_rd_data = '0;
            starve_obs   = 0;
        end else begin
            check("strobe_overlap", !mem_we_n && !mem_oe_n, 1'b0);
            check("busy", busy, rd_ack | wr_ack | prev_ack);
            check("oe_n_window", mem_oe_n, !(rd_ack | prev_rd_ack));
            check("we_n_window", mem_we_n, !wr_ack);
            check("rd_valid_timing", rd_valid, prev2_rd_ack);

            if (rd_valid) begin
                check("rd_valid_expected", rd_q.size() != 0, 1'b1);
                if (rd_q.size() != 0) begin
                    e = rd_q.pop_front();
                    check("rd_data", rd_data, e.data);
                    last_rd_data = e.data;
                end
            end else begin
                check("rd_data_hold", rd_data, last_rd_data);
            end

            if (rd_ack) begin
                check("rd_ack_expected", rd_q.size() != 0, 1'b1);
                if (rd_q.size() != 0) check("rd_mem_addr", mem_addr, rd_q[0].addr);
                if (wr_at_edge) starve_obs++;
            end

            if (!mem_we_n) begin
                check("wr_expected", wr_q.size() != 0, 1'b1);
                if (wr_q.size() != 0) begin
                    e = wr_q.pop_front();
                    check("wr_addr_data", {mem_addr, mem_wdata}, {e.addr, e.data});
                end
                hold_wr     = {mem_addr, mem_wdata};
                prev_we_low = 1'b1;
            end else if (prev_we_low) begin
                check("wr_hold", {mem_addr, mem_wdata}, hold_wr);
                prev_we_low = 1'b0;
            end

            if (wr_ack) begin
                check("starve_bound", starve_obs <= STARVE_MAX, 1'b1);
                starve_obs = 0;
            end

            if (chk_order && (rd_ack || wr_ack)) begin
                check("grant_expected", grant_q.size() != 0, 1'b1);
                if (grant_q.size() != 0) check("grant_order", wr_ack, grant_q.pop_front());
                if (last_ack >= 0) check("grant_gap", cyc - last_ack, 2);
                last_ack = cyc;
            end

            prev2_rd_ack = prev_rd_ack;
            prev_rd_ack  = rd_ack;
            prev_ack     = rd_ack | wr_ack;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int lat;
        int lat_r;
        int lat_w;
        Reset   = 1'b0;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        idle(3);

        // Single read issued at reset release: granted on the first active edge.
        Reset = 1'b1;
        rd_issue(20'h00100, lat);
        check("rd_latency_after_reset", lat, 1);
        rd_req = 1'b0;
        idle(5);

        // Single write.
        wr_issue(20'h00200, 16'h1234, lat);
        check("wr_latency", lat, 1);
        wr_req = 1'b0;
        idle(5);

        // Simultaneous first requests: read first, write at the read's RD2.
        chk_order = 1'b1;
        last_ack  = -1;
        grant_q.push_back(1'b0);
        grant_q.push_back(1'b1);
        fork
            begin
                rd_issue(20'h0A5A5, lat_r);
                rd_req = 1'b0;
            end
            begin
                wr_issue(20'h05A5A, 16'hC0DE, lat_w);
                wr_req = 1'b0;
            end
        join
        check("sim_rd_latency", lat_r, 1);
        check("sim_wr_latency", lat_w, 3);
        idle(4);
        check("sim_grants_drained", grant_q.size(), 0);

        // Both requesters saturated: four reads, then the starved write.
        last_ack = -1;
        for (int i = 0; i < 10; i++) grant_q.push_back(i == 4 || i == 9);
        fork
            reader(8, 0);
            writer(2, 0);
        join
        idle(4);
        check("starve_grants_drained", grant_q.size(), 0);
        chk_order = 1'b0;

        // Reset while in WR1 abandons the write; traffic resumes afterwards.
        wr_issue(20'h00300, 16'h5678, lat);
        Reset  = 1'b0;
        wr_req = 1'b0;
        idle(2);
        Reset = 1'b1;
        wr_issue(20'h00304, 16'h9ABC, lat);
        check("wr_after_reset_latency", lat, 1);
        wr_req = 1'b0;
        idle(3);

        // Reset while in RD1 abandons the read: no rd_valid may follow.
        rd_issue(20'h00400, lat);
        Reset  = 1'b0;
        rd_req = 1'b0;
        @(negedge Clk);
        #1;
        rd_q.delete();
        idle(2);
        Reset = 1'b1;
        rd_issue(20'h00404, lat);
        check("rd_after_reset_latency", lat, 1);
        rd_req = 1'b0;
        idle(4);

        // Random mixed traffic.
        fork
            reader(60, 3);
            writer(40, 4);
        join
        idle(10);
        check("rd_queue_empty", rd_q.size(), 0);
        check("wr_queue_empty", wr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fb_sram_arbiter.md
FB_SRAM_ARBITER -- requirements
Module: fb_sram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 20, SRAM address width.
REQ-002 SHALL have parameter DW, default 16, SRAM data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, max consecutive read grants while a write waits.
REQ-004 SHALL have port Clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports rd_req input 1 (display fetch request) and rd_addr input AW (read address).
REQ-007 SHALL have ports rd_ack output 1 (read grant pulse), rd_valid output 1 (data valid pulse) and rd_data output DW (read data).
REQ-008 SHALL have ports wr_req input 1, wr_addr input AW and wr_data input DW (draw-engine write request).
REQ-009 SHALL have port wr_ack output 1 (write grant pulse).
REQ-010 SHALL have ports mem_addr output AW, mem_wdata output DW, mem_rdata input DW, mem_we_n output 1 and mem_oe_n output 1 (SRAM, active-low strobes).
REQ-011 SHALL have port busy output 1, high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, RD1, RD2, WR1, WR2; the arbitration points are IDLE, RD2 and WR2.
REQ-013 At an arbitration point, a read alone SHALL go to RD1, a write alone to WR1, no request to IDLE.
REQ-014 Simultaneous requests SHALL grant the read, unless the starve count equals STARVE_MAX, in which case the write is granted.
REQ-015 Starve count SHALL increment on each read grant while wr_req=1, clear on a write grant or when wr_req=0, and never exceed STARVE_MAX.
REQ-016 On a read grant at edge k:
- mem_addr SHALL take rd_addr.
- rd_ack SHALL be 1 during cycle k+1 only.
- mem_oe_n SHALL be 0 during RD1 and RD2.
REQ-017 At the RD2 edge, rd_data SHALL register mem_rdata, and rd_valid SHALL be 1 for exactly one cycle (k+3).
REQ-018 On a write grant at edge k:
- mem_addr and mem_wdata SHALL take wr_addr and wr_data.
- wr_ack SHALL be 1 during cycle k+1 only.
- mem_we_n SHALL be 0 in WR1 and 1 in WR2, with address and data held through WR2.
REQ-019 mem_we_n and mem_oe_n SHALL never both be 0 in the same cycle.
REQ-020 Requesters hold req/addr/data until ack is seen; a req still high in the cycle after ack SHALL be treated as a new request.
REQ-021 Back-to-back transactions SHALL sustain one per 2 cycles, with no IDLE cycle inserted between them.
REQ-022 rd_data SHALL hold its last value until the next RD2 capture.
REQ-023 Address arithmetic SHALL be none; addresses pass through unmodified at width AW.

Reset
REQ-024 While Reset=0 at an edge, the block SHALL set:
- state=IDLE, starve count=0;
- mem_we_n=1, mem_oe_n=1;
- rd_ack=0, wr_ack=0, rd_valid=0, busy=0;
- rd_data=0, mem_addr=0, mem_wdata=0.
REQ-025 Reset mid-transaction SHALL abandon it: no further ack or rd_valid, and strobes deasserted from the next edge.
REQ-026 The first arbitration after reset release SHALL occur at the first edge with Reset=1.

Verification
REQ-027 Single read: rd_req=1, rd_addr=0x00100, mem_rdata=0xBEEF -> rd_ack in cycle +1, rd_valid with rd_data=0xBEEF in cycle +3, mem_oe_n low 2 cycles.
REQ-028 Single write: wr_addr=0x00200, wr_data=0x1234 -> wr_ack cycle +1, mem_we_n low exactly 1 cycle, addr/data stable 2 cycles.
REQ-029 Starvation: rd_req and wr_req both held high, STARVE_MAX=4 -> grant order R,R,R,R,W, then repeating; one grant every 2 cycles.
REQ-030 Simultaneous first request (starve count 0) -> read granted, wr_ack not asserted until the read reaches RD2.
REQ-031 Reset=0 asserted during WR1 -> mem_we_n=1 next cycle, no wr_ack pulse, busy=0, later requests served normally.
REQ-032 Strobe check across random traffic -> mem_we_n and mem_oe_n never both 0; busy matches state != IDLE every cycle.
